// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash device model and its host controller:
// command codes, status register bit positions and the device state encoding.
package nor_flash_pkg;

  localparam logic [7:0] CMD_READ_ARRAY    = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS   = 8'h70;
  localparam logic [7:0] CMD_CLEAR_STATUS  = 8'h50;
  localparam logic [7:0] CMD_PROGRAM       = 8'h40;
  localparam logic [7:0] CMD_PROGRAM_ALT   = 8'h10;
  localparam logic [7:0] CMD_ERASE_SETUP   = 8'h20;
  localparam logic [7:0] CMD_ERASE_CONFIRM = 8'hD0;

  localparam int unsigned SR_READY     = 7;
  localparam int unsigned SR_ERASE_ERR = 5;
  localparam int unsigned SR_PROG_ERR  = 4;
  localparam int unsigned SR_RESERVED  = 3;

  typedef enum logic [2:0] {
    RD_ARRAY,
    RD_STATUS,
    PROG_SETUP,
    ERASE_SETUP,
    BUSY_PROG,
    BUSY_ERASE
  } flash_state_e;

  function automatic logic [7:0] status_byte(input logic ready,
                                             input logic erase_err,
                                             input logic prog_err);
    logic [7:0] sr;
    sr               = '0;
    sr[SR_READY]     = ready;
    sr[SR_ERASE_ERR] = erase_err;
    sr[SR_PROG_ERR]  = prog_err;
    return sr;
  endfunction

endpackage

// File: rtl/nor_flash_array.sv
// Flash storage: one combinational read port, one synchronous write port.
// Contents start erased (all ones) and are never touched by any reset.
module nor_flash_array
  import nor_flash_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH] = '{default: '1};

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/nor_flash_device.sv
// Behavioural NOR flash device: command decoder, program/sector-erase engine
// with busy timing, status register and tri-state data bus.
module nor_flash_device
  import nor_flash_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SECTOR_WORDS = 64,
  parameter int unsigned PROG_CYCLES  = 8,
  parameter int unsigned ERASE_CYCLES = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] flash_addr,
  inout  wire logic [DATA_WIDTH-1:0] flash_data,
  input  logic                  flash_ce_n,
  input  logic                  flash_oe_n,
  input  logic                  flash_we_n,
  input  logic                  flash_rst_n,
  output logic                  flash_ready
);

  localparam int unsigned SB      = $clog2(SECTOR_WORDS);
  localparam int unsigned SECW    = ADDR_WIDTH - SB;
  localparam int unsigned CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  flash_state_e          state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [SB:0]           off, off_next;
  logic [SECW-1:0]       sector, sector_next;
  logic                  sr_erase_err, sr_erase_err_next;
  logic                  sr_prog_err, sr_prog_err_next;

  logic                  bus_wr, bus_rd, busy;
  logic [7:0]            cmd;
  logic [DATA_WIDTH-1:0] arr_rdata, arr_wdata, status_word, rd_word, prog_word;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic                  arr_we;

  nor_flash_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .rd_addr (flash_addr),
    .rd_data (arr_rdata),
    .wr_en   (arr_we),
    .wr_addr (arr_waddr),
    .wr_data (arr_wdata)
  );

  assign busy        = (state == BUSY_PROG) || (state == BUSY_ERASE);
  assign flash_ready = !busy;

  // Simultaneous oe_n/we_n low is neither a read nor a write.
  assign bus_wr = !flash_ce_n && !flash_we_n && flash_oe_n && flash_rst_n;
  assign bus_rd = !flash_ce_n && !flash_oe_n && flash_we_n && flash_rst_n && !rst;
  assign cmd    = flash_data[7:0];

  assign status_word = {{(DATA_WIDTH-8){1'b0}}, status_byte(!busy, sr_erase_err, sr_prog_err)};
  assign rd_word     = (state == RD_ARRAY) ? arr_rdata : status_word;
  assign flash_data  = bus_rd ? rd_word : 'z;
  assign prog_word   = arr_rdata & flash_data;

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    off_next          = off;
    sector_next       = sector;
    sr_erase_err_next = sr_erase_err;
    sr_prog_err_next  = sr_prog_err;
    arr_we            = 1'b0;
    arr_waddr         = flash_addr;
    arr_wdata         = prog_word;

    case (state)
      RD_ARRAY, RD_STATUS: begin
        if (bus_wr) begin
          case (cmd)
            CMD_READ_ARRAY:  state_next = RD_ARRAY;
            CMD_READ_STATUS: state_next = RD_STATUS;
            CMD_CLEAR_STATUS: begin
              sr_erase_err_next = 1'b0;
              sr_prog_err_next  = 1'b0;
            end
            CMD_PROGRAM, CMD_PROGRAM_ALT: state_next = PROG_SETUP;
            CMD_ERASE_SETUP:              state_next = ERASE_SETUP;
            default: ;
          endcase
        end
      end
      PROG_SETUP: begin
        if (bus_wr) begin
          arr_we     = 1'b1;
          state_next = BUSY_PROG;
          cnt_next   = CW'(PROG_CYCLES);
          if (prog_word != flash_data) sr_prog_err_next = 1'b1;
        end
      end
      ERASE_SETUP: begin
        if (bus_wr) begin
          if (cmd == CMD_ERASE_CONFIRM) begin
            state_next  = BUSY_ERASE;
            cnt_next    = CW'(ERASE_CYCLES);
            sector_next = flash_addr[ADDR_WIDTH-1:SB];
            off_next    = '0;
          end else begin
            state_next        = RD_STATUS;
            sr_erase_err_next = 1'b1;
            sr_prog_err_next  = 1'b1;
          end
        end
      end
      BUSY_PROG, BUSY_ERASE: begin
        cnt_next = cnt - CW'(1);
        if (cnt <= CW'(1)) state_next = RD_STATUS;
        // Off's top bit marks the whole sector as done; later cycles just wait out the counter.
        if (state == BUSY_ERASE && !off[SB]) begin
          arr_we    = 1'b1;
          arr_waddr = {sector, off[SB-1:0]};
          arr_wdata = '1;
          off_next  = off + 1'b1;
        end
      end
      default: state_next = RD_ARRAY;
    endcase

    if (!flash_rst_n) begin
      state_next        = RD_ARRAY;
      cnt_next          = '0;
      off_next          = '0;
      sr_erase_err_next = 1'b0;
      sr_prog_err_next  = 1'b0;
      arr_we            = 1'b0;
    end
    if (rst) arr_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RD_ARRAY;
      cnt          <= '0;
      off          <= '0;
      sector       <= '0;
      sr_erase_err <= 1'b0;
      sr_prog_err  <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      off          <= off_next;
      sector       <= sector_next;
      sr_erase_err <= sr_erase_err_next;
      sr_prog_err  <= sr_prog_err_next;
    end
  end

endmodule

// File: tb/tb_nor_flash_device.sv
// Scoreboard bench for nor_flash_device: stimulus queues expected bus reads and
// busy-window lengths; independent monitors pop and compare them.
module tb_nor_flash_device;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  flash_addr = '0;
  wire logic [15:0] flash_data;
  logic        flash_ce_n = 1'b1;
  logic        flash_oe_n = 1'b1;
  logic        flash_we_n = 1'b1;
  logic        flash_rst_n = 1'b1;
  logic        flash_ready;

  logic [15:0] tb_data = '0;
  logic        tb_drive = 1'b0;
  assign flash_data = tb_drive ? tb_data : 'z;

  typedef struct {
    logic [15:0] data;
    logic        ready;
    string       name;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  int unsigned busy_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        mon_en = 1'b0;
  int unsigned busy_run = 0;

  always #5 clk = ~clk;

  nor_flash_device #(
    .ADDR_WIDTH   (8),
    .DATA_WIDTH   (16),
    .SECTOR_WORDS (64),
    .PROG_CYCLES  (8),
    .ERASE_CYCLES (80)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flash_addr  (flash_addr),
    .flash_data  (flash_data),
    .flash_ce_n  (flash_ce_n),
    .flash_oe_n  (flash_oe_n),
    .flash_we_n  (flash_we_n),
    .flash_rst_n (flash_rst_n),
    .flash_ready (flash_ready)
  );

  // Read monitor: compares the bus value of every issued read cycle.
  always @(negedge clk) begin
    if (mon_en && !flash_ce_n && !flash_oe_n && flash_we_n) begin
      rd_exp_t e;
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL read_unexpected: got data=%h, required no read", flash_data);
      end else begin
        e = rd_q.pop_front();
        if (flash_data !== e.data || flash_ready !== e.ready) begin
          miscompares++;
          $display("FAIL %s: got data=%h ready=%b, required data=%h ready=%b",
                   e.name, flash_data, flash_ready, e.data, e.ready);
        end
      end
    end
  end

  // Busy monitor: measures each contiguous flash_ready=0 window.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!flash_ready) begin
        busy_run++;
      end else if (busy_run != 0) begin
        vectors++;
        if (busy_q.size() == 0) begin
          miscompares++;
          $display("FAIL busy_unexpected: got %0d busy cycles, required none", busy_run);
        end else begin
          int unsigned exp_len;
          exp_len = busy_q.pop_front();
          if (busy_run != exp_len) begin
            miscompares++;
            $display("FAIL busy_len: got %0d busy cycles, required %0d", busy_run, exp_len);
          end
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish, required finish within 2ms");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flash_ce_n = 1'b1;
    flash_oe_n = 1'b1;
    flash_we_n = 1'b1;
    tb_drive   = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] data);
    flash_addr = addr;
    tb_data    = data;
    tb_drive   = 1'b1;
    flash_ce_n = 1'b0;
    flash_oe_n = 1'b1;
    flash_we_n = 1'b0;
    cycle();
    idle();
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [15:0] exp_data,
                          input logic exp_ready, input string name);
    rd_exp_t e;
    e.data  = exp_data;
    e.ready = exp_ready;
    e.name  = name;
    rd_q.push_back(e);
    flash_addr = addr;
    flash_ce_n = 1'b0;
    flash_oe_n = 1'b0;
    flash_we_n = 1'b1;
    cycle();
    idle();
  endtask

  task automatic wait_ready(input string name);
    int unsigned n;
    n = 0;
    while (!flash_ready && n < 300) begin
      cycle();
      n++;
    end
    if (!flash_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got ready=0 after %0d cycles, required ready=1", name, n);
    end
  endtask

  task automatic program_word(input logic [7:0] addr, input logic [15:0] data);
    busy_q.push_back(8);
    bus_write(addr, 16'h0040);
    bus_write(addr, data);
    wait_ready("program");
  endtask

  initial begin
    idle();
    repeat (2) cycle();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Erased array readable straight after reset
    bus_read(8'h05, 16'hFFFF, 1'b1, "reset_read");

    // Program 0x1234, with a status read during the busy window
    busy_q.push_back(8);
    bus_write(8'h05, 16'h0040);
    bus_write(8'h05, 16'h1234);
    bus_read(8'h05, 16'h0000, 1'b0, "busy_status");
    wait_ready("program1");
    bus_read(8'h05, 16'h0080, 1'b1, "prog_done_status");
    bus_write(8'h00, 16'h00FF);
    bus_read(8'h05, 16'h1234, 1'b1, "prog_readback");

    // Attempted 0->1 program sets SR4; 0x50 clears it
    program_word(8'h05, 16'hFFFF);
    bus_read(8'h05, 16'h0090, 1'b1, "prog_err_status");
    bus_write(8'h00, 16'h0050);
    bus_read(8'h05, 16'h0080, 1'b1, "clear_status");
    bus_write(8'h00, 16'h00FF);
    bus_read(8'h05, 16'h1234, 1'b1, "prog_err_word");

    // Full sector erase of sector 1
    program_word(8'h41, 16'h00FF);
    busy_q.push_back(80);
    bus_write(8'h45, 16'h0020);
    bus_write(8'h45, 16'h00D0);
    wait_ready("erase");
    bus_read(8'h00, 16'h0080, 1'b1, "erase_status");
    bus_write(8'h00, 16'h00FF);
    bus_read(8'h40, 16'hFFFF, 1'b1, "erase_first");
    bus_read(8'h41, 16'hFFFF, 1'b1, "erase_prog_word");
    bus_read(8'h7F, 16'hFFFF, 1'b1, "erase_last");
    bus_read(8'h05, 16'h1234, 1'b1, "erase_other_sector");

    // Bad erase confirm: sequence error, no busy window
    bus_write(8'h45, 16'h0020);
    bus_write(8'h45, 16'h00FF);
    bus_read(8'h45, 16'h00B0, 1'b1, "seq_err_status");
    bus_write(8'h00, 16'h0050);
    bus_write(8'h00, 16'h00FF);
    bus_read(8'h05, 16'h1234, 1'b1, "seq_err_array");

    // flash_rst_n abort after 10 erase cycles
    program_word(8'h40, 16'h0000);
    program_word(8'h49, 16'h0000);
    program_word(8'h4A, 16'h0000);
    program_word(8'h7F, 16'h0000);
    busy_q.push_back(11);
    bus_write(8'h40, 16'h0020);
    bus_write(8'h40, 16'h00D0);
    repeat (10) cycle();
    flash_rst_n = 1'b0;
    cycle();
    flash_rst_n = 1'b1;
    bus_read(8'h40, 16'hFFFF, 1'b1, "abort_first");
    bus_read(8'h49, 16'hFFFF, 1'b1, "abort_tenth");
    bus_read(8'h4A, 16'h0000, 1'b1, "abort_eleventh");
    bus_read(8'h7F, 16'h0000, 1'b1, "abort_last");
    bus_write(8'h00, 16'h0070);
    bus_read(8'h00, 16'h0080, 1'b1, "abort_status");

    // rst asserted mid-program: word already written, status reset
    busy_q.push_back(4);
    bus_write(8'h50, 16'h0040);
    bus_write(8'h50, 16'h00FF);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus_read(8'h50, 16'h00FF, 1'b1, "rst_abort_word");
    bus_write(8'h00, 16'h0070);
    bus_read(8'h00, 16'h0080, 1'b1, "rst_abort_status");

    repeat (3) cycle();
    if (rd_q.size() != 0 || busy_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover_expectations: got %0d reads %0d busy pending, required 0 0",
               rd_q.size(), busy_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nor_flash_device.md
NOR_FLASH_DEVICE -- requirements
Module: nor_flash_device

Interface
REQ-001 Param ADDR_WIDTH, default 8, word-address width (256 words).
REQ-002 Param DATA_WIDTH, default 16, data bus width.
REQ-003 Param SECTOR_WORDS, default 64, words per erase sector (power of 2, divides 2^ADDR_WIDTH).
REQ-004 Param PROG_CYCLES, default 8, busy time of one program operation in clk cycles (>=1).
REQ-005 Param ERASE_CYCLES, default 80, busy time of one sector erase in clk cycles (>=SECTOR_WORDS).
REQ-006 clk  input  1  sole clock, all state changes on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 flash_addr  input  ADDR_WIDTH  word address from host.
REQ-009 flash_data  inout  DATA_WIDTH  bidirectional data bus.
REQ-010 flash_ce_n  input  1  chip enable, active low.
REQ-011 flash_oe_n  input  1  output enable, active low.
REQ-012 flash_we_n  input  1  write enable, active low.
REQ-013 flash_rst_n  input  1  device reset pin, active low.
REQ-014 flash_ready  output  1  1 = ready, 0 = busy.

Function
REQ-015 Bus write strobe SHALL be every rising clk edge with ce_n=0, we_n=0, oe_n=1, flash_rst_n=1; address and data sampled that edge; only data[7:0] decoded as command.
REQ-016 Bus read SHALL be ce_n=0, oe_n=0, we_n=1: device drives flash_data combinationally in same cycle (array word or status per mode); otherwise flash_data SHALL be high-Z.
REQ-017 ce_n=0 with oe_n=0 and we_n=0 together SHALL be ignored (no drive, no write).
REQ-018 States: RD_ARRAY, RD_STATUS, PROG_SETUP, ERASE_SETUP, BUSY_PROG, BUSY_ERASE.
REQ-019 In RD_ARRAY/RD_STATUS: cmd 0xFF -> RD_ARRAY; 0x70 -> RD_STATUS; 0x50 clears SR[5:3], mode unchanged; 0x40 or 0x10 -> PROG_SETUP; 0x20 -> ERASE_SETUP; any other value ignored.
REQ-020 PROG_SETUP, next write: mem[addr] <= mem[addr] AND data (bits only cleared), enter BUSY_PROG, load counter PROG_CYCLES.
REQ-021 ERASE_SETUP, next write 0xD0: latch sector = addr[ADDR_WIDTH-1:log2(SECTOR_WORDS)], enter BUSY_ERASE, load counter ERASE_CYCLES; any other value: set SR5 and SR4 (sequence error), enter RD_STATUS, array unchanged.
REQ-022 BUSY_ERASE SHALL write all-ones to one sector word per cycle, offset 0 upward, completing all SECTOR_WORDS before counter expiry.
REQ-023 Busy states: flash_ready=0, SR7=0, all writes ignored, reads return status; counter decrements each cycle; counter 1 -> next cycle RD_STATUS, flash_ready=1, SR7=1.
REQ-024 Status word: SR7 ready, SR5 erase error, SR4 program error, SR3 reserved 0, other bits 0; upper byte 0.
REQ-025 Program targeting a word whose result differs from data (attempted 0->1) SHALL set SR4; array still gets AND result.
REQ-026 flash_rst_n=0 (sampled each edge): abort any operation, state RD_ARRAY, SR cleared to 0x80, flash_ready=1, no drive; partially erased sector remains partially erased.
REQ-027 Array contents SHALL not be altered by rst or flash_rst_n; initial simulation contents all-ones.

Reset
REQ-028 rst=1 SHALL set state RD_ARRAY, SR=0x80, counter 0, erase offset 0, flash_ready=1, flash_data high-Z; rst overrides all bus activity that cycle.
REQ-029 rst asserted mid-BUSY_PROG/BUSY_ERASE SHALL abort as in REQ-026.

Structure
REQ-030 Shared package nor_flash_pkg SHALL hold command codes (0xFF,0x70,0x50,0x40,0x10,0x20,0xD0), status bit indices and state enum, for reuse by the host controller.
REQ-031 Storage SHALL be sub-module nor_flash_array: one combinational read port, one synchronous write port, no reset.

Verification
REQ-032 Read after rst, addr 0x05 -> flash_data=0xFFFF same cycle, flash_ready=1.
REQ-033 Write 0x0040 then 0x1234 at 0x05 -> flash_ready low exactly 8 cycles, then status read 0x0080, after 0xFF read 0x05 -> 0x1234.
REQ-034 Then program 0xFFFF at 0x05 -> SR4 set (status 0x0090), word stays 0x1234; 0x50 -> status 0x0080.
REQ-035 Write 0x0020 then 0x00D0 at 0x45 -> busy 80 cycles; words 0x40-0x7F read 0xFFFF, word 0x05 unchanged.
REQ-036 Write 0x0020 then 0x00FF -> status 0x00B0, no busy, array unchanged.
REQ-037 flash_rst_n low 1 cycle at erase cycle 10 -> flash_ready=1 next cycle, mode RD_ARRAY, words 0x40-0x49 0xFFFF, remainder of sector unchanged.
